// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector: takes a word of up to
// WIDTH bits and plays it out one bit per clock on `a`, back-to-back if fed in time.
module seq_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH+1)-1:0] in_nbits,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       a,
    output logic                       a_valid,
    output logic                       last
);
    localparam int NW = $clog2(WIDTH+1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [NW-1:0]    lastidx_q, lastidx_d;
    logic             a_q, a_d;
    logic             last_q, last_d;

    logic             accept;
    logic [NW-1:0]    n_eff;
    logic [NW-1:0]    sh_amt;
    logic [NW-1:0]    cnt_inc;
    logic [WIDTH-1:0] aligned;

    assign accept  = in_valid && in_ready;
    assign cnt_inc = cnt_q + NW'(1);

    // 0 and anything past WIDTH both mean a full-width word.
    assign n_eff  = ((in_nbits == '0) || (in_nbits > NW'(WIDTH))) ? NW'(WIDTH) : in_nbits;
    assign sh_amt = NW'(WIDTH) - n_eff;

    // MSB-first left-aligns the active bits so the next bit is always shreg[WIDTH-1].
    assign aligned = MSB_FIRST ? (in_data << sh_amt) : in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            lastidx_q <= '0;
            a_q       <= IDLE_LEVEL;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            lastidx_q <= lastidx_d;
            a_q       <= a_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        lastidx_d = lastidx_q;
        a_d       = a_q;
        last_d    = last_q;
        if (accept) begin
            state_d   = SHIFT;
            cnt_d     = '0;
            lastidx_d = n_eff - NW'(1);
            last_d    = (n_eff == NW'(1));
            if (MSB_FIRST) begin
                a_d     = aligned[WIDTH-1];
                shreg_d = aligned << 1;
            end else begin
                a_d     = aligned[0];
                shreg_d = aligned >> 1;
            end
        end else if (state_q == SHIFT && !last_q) begin
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == lastidx_q);
            if (MSB_FIRST) begin
                a_d     = shreg_q[WIDTH-1];
                shreg_d = shreg_q << 1;
            end else begin
                a_d     = shreg_q[0];
                shreg_d = shreg_q >> 1;
            end
        end else if (state_q == SHIFT) begin
            state_d   = IDLE;
            shreg_d   = '0;
            cnt_d     = '0;
            lastidx_d = '0;
            a_d       = IDLE_LEVEL;
            last_d    = 1'b0;
        end
    end

    always_comb begin
        in_ready = (state_q == IDLE) || last_q;
        a        = a_q;
        a_valid  = (state_q == SHIFT);
        last     = last_q;
    end
endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench: an LSB-first and an MSB-first instance share stimulus and are
// checked bit by bit against hand-derived sequences.
module tb_seq_serializer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [3:0] in_nbits;
    logic       in_valid;
    logic       rdy_l, a_l, av_l, last_l;
    logic       rdy_b, a_b, av_b, last_b;

    int n_chk  = 0;
    int n_fail = 0;
    int accepts;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_nbits(in_nbits),
        .in_valid(in_valid), .in_ready(rdy_l), .a(a_l), .a_valid(av_l), .last(last_l)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_nbits(in_nbits),
        .in_valid(in_valid), .in_ready(rdy_b), .a(a_b), .a_valid(av_b), .last(last_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".a"},     a_l,    1'b0);
        chk({tag, ".av"},    av_l,   1'b0);
        chk({tag, ".last"},  last_l, 1'b0);
        chk({tag, ".rdy"},   rdy_l,  1'b1);
        chk({tag, ".av_b"},  av_b,   1'b0);
        chk({tag, ".rdy_b"}, rdy_b,  1'b1);
    endtask

    // seq_l/seq_b bit k = expected `a` on the k-th cycle after the accept edge.
    task automatic expect_word(input string tag, input logic [7:0] seq_l,
                               input logic [7:0] seq_b, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s.a[%0d]", tag, k),    a_l,    seq_l[k]);
            chk($sformatf("%s.ab[%0d]", tag, k),   a_b,    seq_b[k]);
            chk($sformatf("%s.av[%0d]", tag, k),   av_l,   1'b1);
            chk($sformatf("%s.last[%0d]", tag, k), last_l, (k == n - 1));
            chk($sformatf("%s.lastb[%0d]", tag, k), last_b, (k == n - 1));
            chk($sformatf("%s.rdy[%0d]", tag, k),  rdy_l,  (k == n - 1));
            cyc();
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] n);
        in_data  = d;
        in_nbits = n;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        // Scramble the inputs after the accept edge; the word in flight must not care.
        in_data  = ~d;
        in_nbits = 4'd2;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_nbits = 4'd0;
        cyc();
        cyc();
        reset = 1'b0;
        chk_idle("reset");

        // Single 4-bit word 0100: LSB-first 0,0,1,0; MSB-first 0,1,0,0.
        send(8'h04, 4'd4);
        expect_word("single", 8'h04, 8'h02, 4);
        chk_idle("single_end");

        // Five back-to-back words with in_valid held high.
        accepts  = 0;
        in_data  = 8'h04;
        in_nbits = 4'd4;
        in_valid = 1'b1;
        if (rdy_l) accepts++;
        cyc();
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("stream.a[%0d.%0d]", w, k),    a_l,    (k == 2));
                chk($sformatf("stream.av[%0d.%0d]", w, k),   av_l,   1'b1);
                chk($sformatf("stream.rdy[%0d.%0d]", w, k),  rdy_l,  (k == 3));
                chk($sformatf("stream.last[%0d.%0d]", w, k), last_l, (k == 3));
                if (w == 4 && k == 3) in_valid = 1'b0;
                if (in_valid && rdy_l) accepts++;
                cyc();
            end
        end
        chk("stream.accepts", accepts, 5);
        chk_idle("stream_end");

        // Length boundaries.
        send(8'hFF, 4'd0);
        expect_word("n0", 8'hFF, 8'hFF, 8);
        chk_idle("n0_end");

        send(8'h01, 4'd12);
        expect_word("n12", 8'h01, 8'h80, 8);
        chk_idle("n12_end");

        send(8'h01, 4'd1);
        expect_word("n1", 8'h01, 8'h01, 1);
        chk_idle("n1_end");

        // Bit order: A5 is bit-symmetric, 01/4 is not.
        send(8'hA5, 4'd0);
        expect_word("msbA5", 8'hA5, 8'hA5, 8);
        chk_idle("msbA5_end");

        send(8'h01, 4'd4);
        expect_word("order", 8'h01, 8'h08, 4);
        chk_idle("order_end");

        // Reset mid-word, with a word offered on the reset edge that must be dropped.
        send(8'hF0, 4'd0);
        cyc();
        cyc();
        chk("midrst.bit2_l", a_l, 1'b0);
        chk("midrst.bit2_b", a_b, 1'b1);
        reset    = 1'b1;
        in_data  = 8'h0F;
        in_nbits = 4'd0;
        in_valid = 1'b1;
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_idle("midrst_idle");
        cyc();
        chk_idle("midrst_idle2");
        send(8'h0F, 4'd0);
        expect_word("after_rst", 8'h0F, 8'hF0, 8);
        chk_idle("after_rst_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
